// File: rtl/stopwatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl_if
//
// Purpose: groups the button, enable, display-select and status/time signals
// of the stopwatch sequencer into one bundle. clk and rst_n stay plain ports
// on the design.
//
// Signals:
//   ena        global enable (low freezes every register)
//   btn_ss     raw start/stop button, active-high, asynchronous
//   btn_lc     raw lap/clear button, active-high, asynchronous
//   disp_sel   digit select: 0 tenths, 1 seconds ones, 2 seconds tens, 3 status
//   disp_digit digit value for the segment decoder
//   time_bcd   live time {tens, ones, tenths}
//   state      current state (IDLE=0, RUN=1, PAUSE=2, LAP=3)
//   tick       one-cycle pulse on each 0.1 s increment
//
// Modports: master drives buttons/enable/select and observes the outputs;
// slave is the stopwatch itself.
// ---------------------------------------------------------------------------
interface stopwatch_ctrl_if;
    logic        ena;
    logic        btn_ss;
    logic        btn_lc;
    logic [1:0]  disp_sel;
    logic [3:0]  disp_digit;
    logic [11:0] time_bcd;
    logic [1:0]  state;
    logic        tick;

    modport master (
        output ena,
        output btn_ss,
        output btn_lc,
        output disp_sel,
        input  disp_digit,
        input  time_bcd,
        input  state,
        input  tick
    );

    modport slave (
        input  ena,
        input  btn_ss,
        input  btn_lc,
        input  disp_sel,
        output disp_digit,
        output time_bcd,
        output state,
        output tick
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Purpose: stopwatch sequencer between the board push-buttons and the
// 7-segment decoder. Both buttons are synchronised and debounced into
// single-cycle press events that drive a four-state machine
// (IDLE / RUN / PAUSE / LAP). A prescaler turns clk into 0.1 s ticks that
// advance a 3-digit BCD time counter (00.0 .. 59.9 s, wrapping to 00.0).
// In LAP the display shows a frozen snapshot while the live time keeps
// counting.
//
// Parameters:
//   TICK_COUNT      clk cycles per 0.1 s tick (>= 2)
//   DEBOUNCE_CYCLES consecutive disagreeing edges to accept a level change (>= 1)
//
// Ports:
//   clk    single clock
//   rst_n  asynchronous active-low reset
//   bus    stopwatch_ctrl_if.slave (ena, buttons, disp_sel in;
//          disp_digit, time_bcd, state, tick out)
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter logic [23:0] TICK_COUNT      = 24'd1_000_000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
    input  logic              clk,
    input  logic              rst_n,
    stopwatch_ctrl_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

    // Channel 0 is start/stop, channel 1 is lap/clear.
    logic [1:0] btn_raw;
    logic [1:0] btn_evt;

    assign btn_raw = {bus.btn_lc, bus.btn_ss};

    // -----------------------------------------------------------------------
    // Per-button conditioning: 2-flop synchroniser, debouncer, press detector
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic        sync1_q, sync1_d;
            logic        sync2_q, sync2_d;
            logic        deb_q, deb_d;
            logic        deb_dly_q, deb_dly_d;
            logic        evt_q, evt_d;
            logic [15:0] cnt_q, cnt_d;

            always_comb begin
                sync1_d = btn_raw[gi];
                sync2_d = sync1_q;
                deb_d   = deb_q;
                cnt_d   = 16'd0;
                // The count restarts on any agreeing edge, so only an
                // unbroken run of DEBOUNCE_CYCLES disagreeing edges flips
                // the debounced level.
                if (sync2_q != deb_q) begin
                    if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                        deb_d = ~deb_q;
                        cnt_d = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                deb_dly_d = deb_q;
                // Rising edge of the debounced level only; releases are silent.
                evt_d     = deb_q & ~deb_dly_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    deb_q     <= 1'b0;
                    deb_dly_q <= 1'b0;
                    evt_q     <= 1'b0;
                    cnt_q     <= 16'd0;
                end else if (bus.ena) begin
                    sync1_q   <= sync1_d;
                    sync2_q   <= sync2_d;
                    deb_q     <= deb_d;
                    deb_dly_q <= deb_dly_d;
                    evt_q     <= evt_d;
                    cnt_q     <= cnt_d;
                end
            end

            assign btn_evt[gi] = evt_q;
        end
    endgenerate

    // Start/stop has priority: a lap/clear press landing in the same cycle
    // is dropped.
    logic ss_evt;
    logic lc_evt;

    assign ss_evt = btn_evt[0];
    assign lc_evt = btn_evt[1] & ~btn_evt[0];

    // -----------------------------------------------------------------------
    // BCD increment with carries; 59.9 rolls over to 00.0.
    // -----------------------------------------------------------------------
    function automatic logic [11:0] bcd_inc(input logic [11:0] t);
        logic [3:0] d_tenths;
        logic [3:0] d_ones;
        logic [3:0] d_tens;
        d_tenths = t[3:0];
        d_ones   = t[7:4];
        d_tens   = t[11:8];
        if (d_tenths == 4'd9) begin
            d_tenths = 4'd0;
            if (d_ones == 4'd9) begin
                d_ones = 4'd0;
                if (d_tens == 4'd5) begin
                    d_tens = 4'd0;
                end else begin
                    d_tens = d_tens + 4'd1;
                end
            end else begin
                d_ones = d_ones + 4'd1;
            end
        end else begin
            d_tenths = d_tenths + 4'd1;
        end
        return {d_tens, d_ones, d_tenths};
    endfunction

    // -----------------------------------------------------------------------
    // State machine, prescaler, time counter and lap snapshot
    // -----------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic [23:0] presc_q, presc_d;
    logic [11:0] time_q, time_d;
    logic [11:0] snap_q, snap_d;
    logic        tick_q, tick_d;
    logic        counting;

    assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);

    always_comb begin
        presc_d = presc_q;
        time_d  = time_q;
        tick_d  = 1'b0;
        state_d = state_q;
        snap_d  = snap_q;

        // Counting follows the current state, so a tick that coincides with
        // a stop press is still applied on the transition edge. In PAUSE the
        // prescaler holds its partial interval.
        if (counting) begin
            if (presc_q == TICK_COUNT - 24'd1) begin
                presc_d = 24'd0;
                tick_d  = 1'b1;
                time_d  = bcd_inc(time_q);
            end else begin
                presc_d = presc_q + 24'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (ss_evt) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ss_evt) begin
                    state_d = ST_PAUSE;
                end else if (lc_evt) begin
                    state_d = ST_LAP;
                    // Snapshot takes the post-increment value so it matches
                    // what time_bcd shows right after the transition.
                    snap_d  = time_d;
                end
            end
            ST_LAP: begin
                if (ss_evt) begin
                    state_d = ST_PAUSE;
                end else if (lc_evt) begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (ss_evt) begin
                    state_d = ST_RUN;
                end else if (lc_evt) begin
                    state_d = ST_IDLE;
                    time_d  = 12'h000;
                    presc_d = 24'd0;
                    snap_d  = 12'h000;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= 24'd0;
            time_q  <= 12'h000;
            snap_q  <= 12'h000;
            tick_q  <= 1'b0;
        end else if (bus.ena) begin
            state_q <= state_d;
            presc_q <= presc_d;
            time_q  <= time_d;
            snap_q  <= snap_d;
            tick_q  <= tick_d;
        end
    end

    // -----------------------------------------------------------------------
    // Display mux: combinational from disp_sel and registered sources only.
    // -----------------------------------------------------------------------
    logic [11:0] disp_src;
    logic [3:0]  disp_digit;

    always_comb begin
        disp_src = (state_q == ST_LAP) ? snap_q : time_q;
        case (bus.disp_sel)
            2'd0:    disp_digit = disp_src[3:0];
            2'd1:    disp_digit = disp_src[7:4];
            2'd2:    disp_digit = disp_src[11:8];
            default: disp_digit = {2'b00, state_q};
        endcase
    end

    assign bus.disp_digit = disp_digit;
    assign bus.time_bcd   = time_q;
    assign bus.state      = state_q;
    assign bus.tick       = tick_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch sequencer that sits between the board push-buttons and the 7-segment decoder. It debounces two buttons and runs a four-state start/stop/lap/clear machine. It gates a prescaled tick into a 3-digit BCD time counter (00.0–59.9 s) and selects which live or lap-frozen digit is presented to the segment decoder.

## Interface
- `TICK_COUNT`, default 24'd1_000_000: clk cycles per 0.1 s tick (10 MHz clock). Legal range is ≥2.
- `DEBOUNCE_CYCLES`, default 16'd50_000: consecutive disagreeing edges needed to accept a button level change. Legal range is ≥1.
- `clk`  in  1: the single clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `ena`  in  1: global enable. While low, every register holds its value.
- `btn_ss`  in  1: raw start/stop button, active-high, asynchronous to clk.
- `btn_lc`  in  1: raw lap/clear button, active-high, asynchronous to clk.
- `disp_sel`  in  2: digit select. 0 = tenths, 1 = seconds ones, 2 = seconds tens, 3 = status.
- `disp_digit`  out  4: digit value driven to the segment decoder.
- `time_bcd`  out  12: live time as {tens, ones, tenths}.
- `state`  out  2: current state. IDLE=0, RUN=1, PAUSE=2, LAP=3.
- `tick`  out  1: one-cycle pulse on each 0.1 s increment.

## Operation
- **Input conditioning:** each button passes through a 2-flop synchroniser and then a debouncer.
- **Debouncer counter:** counts edges on which the synchronised level differs from the debounced level. It clears on any agreeing edge.
- **Debounced level:** toggles on the `DEBOUNCE_CYCLES`-th consecutive differing edge.
- **Press event:** a registered 1-cycle pulse, issued on each 0→1 transition of the debounced level. Releases generate no event.
- **Simultaneous events:** if `ss_evt` and `lc_evt` are high in the same cycle, `ss_evt` wins and `lc_evt` is discarded.
- **State transitions** (taken on the edge that ends the event cycle):
  - IDLE: `ss` → RUN. `lc` is ignored.
  - RUN: `ss` → PAUSE. `lc` → LAP and loads the lap snapshot.
  - LAP: `lc` → RUN (display returns to live). `ss` → PAUSE (display returns to live).
  - PAUSE: `ss` → RUN. `lc` → IDLE and clears time, prescaler and snapshot to 0.
- **Prescaler:** counts only in RUN and LAP. When it equals `TICK_COUNT-1` it wraps to 0 and `tick` is asserted.
- **Prescaler in PAUSE:** holds its value, so a resumed run keeps the partial 0.1 s interval.
- **Time counter:** BCD; each digit is always in 0–9, and tens in 0–5.
  - On `tick`, tenths increments, with a 9→0 carry into ones.
  - Ones 9→0 carries into tens.
  - 59.9 wraps to 00.0 with no flag.
- **Tick coinciding with a stop event:** the increment is still applied, and the state becomes PAUSE on the same edge.
- **Lap snapshot:** captures the post-increment time value, i.e. the value `time_bcd` shows in the cycle after the transition.
- **Display source:** the snapshot in LAP, the live time in every other state.
- **Status digit:** with `disp_sel`=3, `disp_digit` = {2'b00, `state`}.
- **`disp_digit` timing:** combinational from `disp_sel` and registered sources.
- **Reset mid-operation:** asserting `rst_n` low at any time forces IDLE immediately.

## Timing
- **Reset values:** `state`=IDLE, `time_bcd`=12'h000, snapshot=0, `tick`=0. Prescaler, synchronisers, debounced levels, debounce counters and event pulses are all 0. Hence `disp_digit`=0 for every `disp_sel`.
- **Press latency:** raw press first sampled at edge E, held stable.
  - Synchroniser output goes high after E+1.
  - Debounced level goes high after E+1+D, where D=`DEBOUNCE_CYCLES`.
  - Event pulse is high during the cycle after E+2+D.
  - `state` changes at edge E+3+D.
- **Glitch rejection:** a raw pulse shorter than D synchronised cycles produces no event.
- **Tick timing:** `tick` is high in the cycle after the prescaler's terminal edge. `time_bcd` updates on that same edge. So the first tick after entering RUN (prescaler 0) arrives `TICK_COUNT` edges after the RUN transition.
- **`ena` low:** freezes all counters and pipelines exactly. There is no catch-up on re-enable.

## Test plan
Bench parameters: `TICK_COUNT`=4, `DEBOUNCE_CYCLES`=3.

- **Reset:** assert `rst_n` low mid-RUN with time 01.2 → `state`=0, `time_bcd`=000, `tick`=0 immediately, with no clock needed.
- **Debounce:** 2-cycle glitch on `btn_ss` → no state change. Clean press sampled at edge E → `state`=1 exactly at edge E+6.
- **Counting and wrap:** RUN for 600×4 cycles from 00.0 → `time_bcd` passes 09.9→10.0, then 59.9→00.0. Exactly one `tick` per 4 cycles.
- **Lap:** RUN until 03.7, then `lc` press → `state`=3, displayed digits read 7,3,0 while `time_bcd` keeps advancing. Second `lc` → display is live again.
- **Pause/resume/clear:** `ss` with prescaler=2 → PAUSE, prescaler holds 2. `ss` again → next `tick` after 2 edges. Pause and `lc` → IDLE, `time_bcd`=000.
- **Contention and enable:** `ss` and `lc` events in the same cycle in RUN → PAUSE, lap ignored. `ena`=0 for 10 cycles during RUN → `time_bcd` and prescaler unchanged.
